// File: rtl/decode_pkg.sv
// Shared definitions for the wide decode stage.
//   - RV32 base opcode constants
//   - immediate-type codes (RT/IT/ST/BT/UT/JT, NT = no immediate/unknown)
//   - issue-queue codes (NONE/MEMQ/ALUQ) and priority values
//   - bit offsets of the per-lane ctrl field {priority, queue, lane valid}
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {RT, IT, ST, BT, UT, JT, NT} imm_type_e;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    MEMQ = 2'b01,
    ALUQ = 2'b10
  } queue_e;

  localparam logic [1:0] PRIO_NONE = 2'b00;
  localparam logic [1:0] PRIO_HIGH = 2'b11;

  localparam int unsigned CTRL_VALID = 0;
  localparam int unsigned CTRL_QUEUE = 1;
  localparam int unsigned CTRL_PRIO  = 3;
  localparam int unsigned CTRL_W     = 5;

  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    imm_type_e t;
    case (opcode)
      OP_REG:                  t = RT;
      OP_LOAD, OP_IMM, OP_JALR: t = IT;
      OP_STORE:                t = ST;
      OP_BRANCH:               t = BT;
      OP_LUI, OP_AUIPC:        t = UT;
      OP_JAL:                  t = JT;
      default:                 t = NT;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/decode_lane.sv
// Combinational decode of one instruction.
//   instr_i   : 32-bit instruction
//   valid_i   : lane valid (group valid & lane mask)
//   uop_o     : opcode (0 for an invalid lane)
//   regs_o    : {rd, rs2, rs1}, unused fields 0
//   func_o    : {funct7, funct3}, unused fields 0
//   ctrl_o    : {priority[1:0], queue[1:0], lane valid}
//   imm_o     : sign-extended immediate (0 when the format has none)
//   is_jump_o : lane is a valid branch, JAL or JALR
// Build option DECODE_SHIFT_FUNCT7_EN: I-type shifts keep funct7 so SRLI/SRAI differ.
module decode_lane
  import decode_pkg::*;
(
  input  logic [31:0]       instr_i,
  input  logic              valid_i,
  output logic [6:0]        uop_o,
  output logic [14:0]       regs_o,
  output logic [9:0]        func_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [31:0]       imm_o,
  output logic              is_jump_o
);

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;
  queue_e     queue;
  logic [1:0] prio;
  logic       is_jump;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  always_comb begin
    uop_o   = '0;
    regs_o  = '0;
    func_o  = '0;
    imm_o   = '0;
    ctrl_o  = '0;
    is_jump = 1'b0;
    queue   = NONE;
    prio    = PRIO_NONE;
    if (valid_i) begin
      uop_o   = opcode;
      is_jump = (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
      prio    = is_jump ? PRIO_HIGH : PRIO_NONE;
      // Loads and stores share the 0?00011 pattern.
      queue   = ({opcode[6], opcode[4:0]} == 6'b000011) ? MEMQ : ALUQ;
      unique case (imm_type_of(opcode))
        RT: begin
          regs_o = {rd, rs2, rs1};
          func_o = {funct7, funct3};
        end
        IT: begin
          regs_o = {rd, 5'b0, rs1};
          func_o = {7'b0, funct3};
`ifdef DECODE_SHIFT_FUNCT7_EN
          if (opcode == OP_IMM && (funct3 == 3'b001 || funct3 == 3'b101)) begin
            func_o = {funct7, funct3};
          end
`endif
          imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
        end
        ST: begin
          regs_o = {5'b0, rs2, rs1};
          func_o = {7'b0, funct3};
          imm_o  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        end
        BT: begin
          regs_o = {5'b0, rs2, rs1};
          func_o = {7'b0, funct3};
          imm_o  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
        end
        UT: begin
          regs_o = {rd, 10'b0};
          imm_o  = {instr_i[31:12], 12'b0};
        end
        JT: begin
          regs_o = {rd, 10'b0};
          imm_o  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};
        end
        default: ;
      endcase
    end
    ctrl_o[CTRL_VALID]    = valid_i;
    ctrl_o[CTRL_QUEUE +: 2] = queue;
    ctrl_o[CTRL_PRIO +: 2]  = prio;
  end

  assign is_jump_o = is_jump;

endmodule

// File: rtl/decode_wide.sv
// Multi-lane decode stage with one-hot branch-tag allocation.
//   i_clk/i_rst          : clock, synchronous active-high reset
//   i_valid/o_ready      : fetch group handshake (group accepted atomically)
//   i_instr/i_imask      : DEC_W instructions and per-lane valid
//   o_valid/i_ready      : registered decoded group to rename/dispatch
//   o_uop/o_regs/o_func/o_ctrl/o_imm : per-lane decoded fields
//   o_brtag/o_brmask     : tag owned by the lane / outstanding tags it depends on
//   i_br_free            : tags resolved this cycle
//   i_flush/i_flush_mask : mispredict flush and the tags it kills
// Build option DECODE_SHIFT_FUNCT7_EN is consumed by decode_lane.
module decode_wide
  import decode_pkg::*;
#(
  parameter int unsigned DEC_W     = 2,
  parameter int unsigned WIDTH_BRM = 6
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [32*DEC_W-1:0]        i_instr,
  input  logic [DEC_W-1:0]           i_imask,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [7*DEC_W-1:0]         o_uop,
  output logic [15*DEC_W-1:0]        o_regs,
  output logic [10*DEC_W-1:0]        o_func,
  output logic [5*DEC_W-1:0]         o_ctrl,
  output logic [32*DEC_W-1:0]        o_imm,
  output logic [WIDTH_BRM*DEC_W-1:0] o_brtag,
  output logic [WIDTH_BRM*DEC_W-1:0] o_brmask,
  input  logic [WIDTH_BRM-1:0]       i_br_free,
  input  logic                       i_flush,
  input  logic [WIDTH_BRM-1:0]       i_flush_mask
);

  logic [6:0]           lane_uop  [DEC_W];
  logic [14:0]          lane_regs [DEC_W];
  logic [9:0]           lane_func [DEC_W];
  logic [CTRL_W-1:0]    lane_ctrl [DEC_W];
  logic [31:0]          lane_imm  [DEC_W];
  logic [DEC_W-1:0]     lane_jump;
  logic [WIDTH_BRM-1:0] lane_tag  [DEC_W];
  logic [WIDTH_BRM-1:0] lane_mask [DEC_W];

  logic [WIDTH_BRM-1:0] busy_q, busy_d, avail, alloc;
  logic                 valid_q, valid_d;
  logic                 ready, accept;
  int unsigned          need, free;

  logic [7*DEC_W-1:0]         uop_q;
  logic [15*DEC_W-1:0]        regs_q;
  logic [10*DEC_W-1:0]        func_q;
  logic [5*DEC_W-1:0]         ctrl_q;
  logic [32*DEC_W-1:0]        imm_q;
  logic [WIDTH_BRM*DEC_W-1:0] brtag_q, brmask_q;

  for (genvar k = 0; k < DEC_W; k++) begin : g_lane
    decode_lane u_lane (
      .instr_i   (i_instr[32*k +: 32]),
      .valid_i   (i_valid & i_imask[k]),
      .uop_o     (lane_uop[k]),
      .regs_o    (lane_regs[k]),
      .func_o    (lane_func[k]),
      .ctrl_o    (lane_ctrl[k]),
      .imm_o     (lane_imm[k]),
      .is_jump_o (lane_jump[k])
    );
  end

  always_comb begin
    avail = ~busy_q;
    alloc = '0;
    need  = 0;
    free  = 0;
    for (int b = 0; b < WIDTH_BRM; b++) begin
      if (!busy_q[b]) free++;
    end
    for (int k = 0; k < DEC_W; k++) begin
      // Tags resolving this cycle are already dropped from the dependency mask.
      lane_mask[k] = (busy_q & ~i_br_free) | alloc;
      lane_tag[k]  = '0;
      if (lane_jump[k]) begin
        need++;
        // Isolate the lowest still-available tag.
        lane_tag[k] = avail & (~avail + WIDTH_BRM'(1));
        avail       = avail & ~lane_tag[k];
        alloc       = alloc | lane_tag[k];
      end
    end
    ready   = (!valid_q || i_ready) && (need <= free) && !i_flush;
    accept  = i_valid && ready;
    busy_d  = (busy_q | (accept ? alloc : '0)) & ~i_br_free
              & ~(i_flush ? i_flush_mask : '0);
    if (i_flush)     valid_d = 1'b0;
    else if (accept) valid_d = 1'b1;
    else if (i_ready) valid_d = 1'b0;
    else             valid_d = valid_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q   <= '0;
      valid_q  <= 1'b0;
      uop_q    <= '0;
      regs_q   <= '0;
      func_q   <= '0;
      ctrl_q   <= '0;
      imm_q    <= '0;
      brtag_q  <= '0;
      brmask_q <= '0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      for (int k = 0; k < DEC_W; k++) begin
        if (accept) begin
          uop_q[7*k +: 7]                   <= lane_uop[k];
          regs_q[15*k +: 15]                <= lane_regs[k];
          func_q[10*k +: 10]                <= lane_func[k];
          ctrl_q[5*k +: 5]                  <= lane_ctrl[k];
          imm_q[32*k +: 32]                 <= lane_imm[k];
          brtag_q[WIDTH_BRM*k +: WIDTH_BRM]  <= lane_tag[k];
          brmask_q[WIDTH_BRM*k +: WIDTH_BRM] <= lane_mask[k];
        end else begin
          // A held group drops dependencies as their branches resolve.
          brmask_q[WIDTH_BRM*k +: WIDTH_BRM] <= brmask_q[WIDTH_BRM*k +: WIDTH_BRM] & ~i_br_free;
        end
      end
    end
  end

  assign o_ready  = ready;
  assign o_valid  = valid_q;
  assign o_uop    = uop_q;
  assign o_regs   = regs_q;
  assign o_func   = func_q;
  assign o_ctrl   = ctrl_q;
  assign o_imm    = imm_q;
  assign o_brtag  = brtag_q;
  assign o_brmask = brmask_q;

endmodule

// File: doc/decode_wide.md
# decode_wide

Parametrised multi-lane decode stage with branch-tag allocation. Accepts a group of up to DEC_W fetched instructions per cycle, decodes each into uop, register, function, control and immediate fields, and assigns a one-hot branch tag to every branch or jump. Its output is registered and feeds rename/dispatch through a valid/ready handshake. The block stalls when the free branch-tag pool cannot cover the whole group, and it tracks branch resolution and flush.

## Interface
- DEC_W, 2, number of decode lanes (1..4)
- WIDTH_BRM, 6, number of branch tags; width of all branch masks
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  fetch group valid
- o_ready  out  1  group accepted this cycle when i_valid & o_ready
- i_instr  in  32*DEC_W  instructions; lane k = bits [32k+31:32k]
- i_imask  in  DEC_W  per-lane instruction valid
- o_valid  out  1  decoded group valid
- i_ready  in  1  downstream accepts group
- o_uop  out  7*DEC_W  opcode per lane
- o_regs  out  15*DEC_W  {rd, rs2, rs1} per lane; unused fields are 0
- o_func  out  10*DEC_W  {funct7, funct3} per lane
- o_ctrl  out  5*DEC_W  {priority[1:0], queue[1:0], lane valid}
- o_imm  out  32*DEC_W  sign-extended immediate
- o_brtag  out  WIDTH_BRM*DEC_W  one-hot tag owned by the lane, or 0
- o_brmask  out  WIDTH_BRM*DEC_W  outstanding tags the lane depends on
- i_br_free  in  WIDTH_BRM  tags resolved this cycle
- i_flush  in  1  mispredict flush
- i_flush_mask  in  WIDTH_BRM  tags killed by the flush

## Operation
- A lane is a jump if it is valid and its opcode is 1100011, 1101111 or 1100111.
- Per-lane decode:
  - R-type: rd, rs2, rs1, funct7 and funct3.
  - I-type: rd and rs1; funct3 only.
  - S-type and B-type: rs2 and rs1; funct3 only.
  - U-type and J-type: rd only.
  - Any other opcode, or an invalid lane: regs and func are 0.
- priority is 11 for B-type, J-type and JALR; otherwise 00.
- queue:
  - MEMQ (01) for opcode 0?00011.
  - ALUQ (10) for any other valid lane.
  - NONE (00) for an invalid lane.
- Ctrl bit 0 is i_valid & i_imask[k].
- busy register (WIDTH_BRM) marks allocated tags.
- need = number of jump lanes. free = popcount(~busy).
- Allocation:
  - Tags are assigned lowest free index first, to lanes in ascending order.
  - o_brtag[k] is the assigned tag; non-jump lanes get 0.
- o_brmask[k] = (busy & ~i_br_free) | tags of jump lanes j < k in the same group.
- o_ready = (!o_valid | i_ready) & (need <= free) & !i_flush.
  - Groups are atomic: either all lanes are accepted or none.
- On accept:
  - Output registers load.
  - o_valid = 1.
  - Allocated tags are set in busy.
- On i_valid & !o_ready: nothing changes except resolution and flush effects.
- While held (o_valid & !i_ready), registered o_brmask bits in i_br_free are cleared each cycle.
- busy next = (busy | alloc) & ~i_br_free & ~(i_flush ? i_flush_mask : 0).
- Flush:
  - o_valid is cleared next cycle.
  - The input group is not accepted.
  - Killed tags are freed.

## Timing
- Reset: o_valid = 0, busy = 0, and all output data registers = 0.
- Reset mid-operation discards the held group and all tags.
- Latency: 1 cycle from accept to o_valid.
- Throughput: 1 group per cycle when i_ready is held high and tags are available.
- Tags freed in cycle t:
  - They are available for allocation from cycle t+1 (free is computed from registered busy).
  - They are already masked out of o_brmask in cycle t.
- A tag present in both i_br_free and the allocation in the same cycle is impossible, because allocation uses only ~busy.
- Flush and accept in the same cycle: the flush wins.
- Boundary cases:
  - busy all ones and need = 0: the group is accepted.
  - need = 0 after i_imask masking: allocation is not required.

## Configuration
- DECODE_SHIFT_FUNCT7_EN
  - Defined: for opcode 0010011 with funct3 001 or 101, o_func = {instr[31:25], funct3}, so SRAI and SRLI are distinguished.
  - Undefined: all I-type lanes use o_func[9:3] = 0.

## Structure
- Shared package decode_pkg holds:
  - opcode constants;
  - immediate-type codes RT/IT/ST/BT/UT/JT;
  - queue codes NONE/MEMQ/ALUQ;
  - priority values;
  - ctrl field offsets.
- Sub-module decode_lane (combinational, one instruction) is instantiated DEC_W times.
- Tag allocation, busy and output registers live in the top level.

## Test plan
- Reset, then a DEC_W=2 group {add x3,x1,x2; lw x5,8(x4)}:
  - Next cycle: o_valid=1, lane0 regs={3,2,1}, func={0,0}, queue ALUQ; lane1 imm=8, queue MEMQ.
  - o_brtag = 0 for both lanes.
- Group {beq; jal} with busy=0:
  - Lane0 tag 000001, lane1 tag 000010.
  - Lane1 brmask 000001; busy becomes 000011.
- busy=111110 with a group of two branches:
  - o_ready=0 and the group is held.
  - Assert i_br_free=000010: accepted the next cycle, with tags 000001 and 000010.
- Hold i_ready=0 with the output brmask=000011, then i_br_free=000001:
  - The registered brmask becomes 000010 the next cycle.
- i_flush with i_flush_mask=000011 while o_valid=1:
  - o_valid=0 next cycle, busy clears bits 0–1, and the input is not accepted.
- srai x1,x2,3:
  - Macro defined: func = {0100000, 101}.
  - Macro undefined: func = {0000000, 101}.
